alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal values 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and op presented this cycle.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SHL, 7 MUL.
REQ-009 out_valid  output  1  registered result available.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 res  output  WIDTH  result, low half for MUL.
REQ-012 res_hi  output  WIDTH  MUL high half; 0 for all other ops.
REQ-013 cout  output  1  carry out; 0 for ops other than ADD/SUB.
REQ-014 ovf  output  1  signed overflow; 0 for ops other than ADD/SUB.
REQ-015 zero  output  1  1 when res (and res_hi for MUL) are all zero.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 exactly in IDLE; a request is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-018 On acceptance, a, b, op SHALL be captured; later changes on a, b, op SHALL not affect the result.
REQ-019 Ops 0..6, once accepted, SHALL go IDLE -> DONE, with out_valid=1 in the next cycle (latency 1).
REQ-020 MUL, once accepted, SHALL go IDLE -> BUSY, perform unsigned shift-add one bit per cycle for WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-021 In DONE, out_valid=1 and res, res_hi, cout, ovf, zero SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-022 out_ready while not in DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored (no queuing).
REQ-023 ADD: {cout,res} = a + b, WIDTH+1-bit sum; ovf = operands same sign, result sign differs.
REQ-024 SUB: {cout,res} = a + ~b + 1; cout=1 means no borrow; ovf = operand signs differ, result sign differs from a.
REQ-025 AND/OR/XOR: bitwise; SLT: res = 1 if signed a < signed b else 0; SHL: res = a << b[clog2(WIDTH)-1:0], zero-fill.
REQ-026 MUL: {res_hi,res} = full 2*WIDTH-bit unsigned product; cout=ovf=0.
REQ-027 Results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-028 Output registers SHALL change only on the edge entering DONE, or under reset.

Reset
REQ-029 rstn=0 SHALL immediately, without a clock edge, force state IDLE, in_ready=1, out_valid=0, res=res_hi=0, cout=ovf=0, zero=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; no result is presented after release.
REQ-031 After rstn release, the first accepted request SHALL behave identically to one after power-up.

Verification (WIDTH=8)
REQ-032 ADD a=0xFF b=0x01 -> next cycle out_valid=1, res=0x00, cout=1, ovf=0, zero=1.
REQ-033 SUB a=0x80 b=0x01 -> res=0x7F, cout=1, ovf=1; SLT a=0x80 b=0x01 -> res=0x01.
REQ-034 MUL a=0xFF b=0xFF -> in_ready=0 for 9 cycles, out_valid on cycle 9, res_hi=0xFE, res=0x01, zero=0.
REQ-035 AND a=0xF0 b=0x0F with out_ready=0 for 5 cycles -> res=0x00, zero=1, cout=0 held stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-036 rstn pulsed low 3 cycles into MUL -> outputs zero asynchronously, out_valid never rises, next ADD 0x03+0x04 -> res=0x07.
REQ-037 SHL a=0x81 b=0x09 (shift 1) -> res=0x02; changing a/b after acceptance leaves result unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: single-request ALU with a valid/ready handshake on both sides.
// Ops 0..6 complete in one cycle. MUL runs an unsigned shift-add, one
// multiplier bit per cycle. The result is held until the consumer accepts it.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   c_res;
  logic               c_cout;
  logic               c_ovf;
  logic               accept;
  logic               load_alu;
  logic               load_mul;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign load_alu  = accept && (op != OP_MUL);
  assign load_mul  = (state == BUSY) && (cnt == LAST);
  assign prod_next = mplier[0] ? (prod + mcand) : prod;

  // Single-cycle ops evaluate straight from the live inputs; only the
  // accepting edge loads them, so later input changes cannot leak in.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    c_res  = '0;
    c_cout = 1'b0;
    c_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        c_res  = sum[WIDTH-1:0];
        c_cout = sum[WIDTH];
        c_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res  = dif[WIDTH-1:0];
        c_cout = dif[WIDTH];
        c_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  c_res = a & b;
      OP_OR:   c_res = a | b;
      OP_XOR:  c_res = a ^ b;
      OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  c_res = a << b[SW-1:0];
      default: c_res = '0;
    endcase
  end

  // Control FSM and the shift-add multiplier datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state  <= BUSY;
              cnt    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              prod   <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          prod   <= prod_next;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers: loaded only on the edge that enters DONE. The last
  // multiply step is folded into that load via prod_next, so MUL spends
  // exactly WIDTH cycles in BUSY.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res    <= '0;
      res_hi <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (load_alu) begin
      res    <= c_res;
      res_hi <= '0;
      cout   <= c_cout;
      ovf    <= c_ovf;
      zero   <= (c_res == '0);
    end else if (load_mul) begin
      res    <= prod_next[WIDTH-1:0];
      res_hi <= prod_next[2*WIDTH-1:WIDTH];
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= (prod_next == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal cases plus randomized traffic, checked
// every cycle against a transaction-level model of alu_seq.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .cout(cout), .ovf(ovf), .zero(zero)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Arithmetic reference: plain integer maths on the operand values.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic [W-1:0] h,
                                 output logic c, output logic v, output logic z);
    longint ua, ub, sa, sb, t, mask, smax, smin;
    ua   = longint'(x);
    ub   = longint'(y);
    mask = (longint'(1) << W) - 1;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(smax + 1);
    sa   = (ua > smax) ? ua - (mask + 1) : ua;
    sb   = (ub > smax) ? ub - (mask + 1) : ub;
    t = 0; c = 1'b0; v = 1'b0; h = '0;
    case (o)
      3'd0: begin t = ua + ub; c = (t > mask); v = (sa + sb > smax) || (sa + sb < smin); end
      3'd1: begin t = ua - ub; c = (ua >= ub); v = (sa - sb > smax) || (sa - sb < smin); end
      3'd2: t = ua & ub;
      3'd3: t = ua | ub;
      3'd4: t = ua ^ ub;
      3'd5: t = (sa < sb) ? 1 : 0;
      3'd6: t = ua << (ub % W);
      default: begin t = ua * ub; h = W'((t >> W) & mask); end
    endcase
    r = W'(t & mask);
    z = (r == '0) && (h == '0);
  endfunction

  // Transaction model: a countdown until the result shows, then a held result.
  int           m_wait = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] e_res = '0, e_hi = '0, p_res = '0, p_hi = '0;
  logic         e_c = 1'b0, e_v = 1'b0, e_z = 1'b0, p_c = 1'b0, p_v = 1'b0, p_z = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_wait = 0; m_done = 1'b0;
      e_res = '0; e_hi = '0; e_c = 1'b0; e_v = 1'b0; e_z = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        e_res = p_res; e_hi = p_hi; e_c = p_c; e_v = p_v; e_z = p_z; m_done = 1'b1;
      end
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      ref_op(op, a, b, p_res, p_hi, p_c, p_v, p_z);
      if (op == 3'd7) m_wait = W;
      else begin
        e_res = p_res; e_hi = p_hi; e_c = p_c; e_v = p_v; e_z = p_z; m_done = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_in_ready", in_ready, (!m_done && m_wait == 0));
    chk("m_out_valid", out_valid, m_done);
    chk("m_res", res, e_res);
    chk("m_res_hi", res_hi, e_hi);
    chk("m_cout", cout, e_c);
    chk("m_ovf", ovf, e_v);
    chk("m_zero", zero, e_z);
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    acc = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
  endtask

  task automatic collect(input int hold, input bit rnd, output int lat,
                         output logic [W-1:0] r, output logic [W-1:0] h,
                         output logic c, output logic v, output logic z);
    bit got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin got = 1'b1; break; end
      if (rnd) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
        op = 3'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!got) chk("result_timeout", 0, 1);
    r = res; h = res_hi; c = cout; v = ovf; z = zero;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (rnd) begin in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    logic [W-1:0] r, h;
    logic c, v, z;
    logic [2:0] ro;

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", {res_hi, res}, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    send(3'd0, 8'hFF, 8'h01);
    collect(0, 0, lat, r, h, c, v, z);
    chk("add_lat", lat, 1);
    chk("add_res", r, 8'h00);
    chk("add_cout", c, 1);
    chk("add_ovf", v, 0);
    chk("add_zero", z, 1);
    chk("add_ready_after", in_ready, 1);

    send(3'd1, 8'h80, 8'h01);
    collect(0, 0, lat, r, h, c, v, z);
    chk("sub_res", r, 8'h7F);
    chk("sub_cout", c, 1);
    chk("sub_ovf", v, 1);

    send(3'd5, 8'h80, 8'h01);
    collect(0, 0, lat, r, h, c, v, z);
    chk("slt_res", r, 8'h01);

    send(3'd7, 8'hFF, 8'hFF);
    for (int k = 1; k <= W + 1; k++) begin
      chk("mul_in_ready", in_ready, 0);
      chk("mul_out_valid", out_valid, (k == W + 1));
      if (k < W + 1) begin @(posedge clk); #1; end
    end
    chk("mul_res_hi", res_hi, 8'hFE);
    chk("mul_res", res, 8'h01);
    chk("mul_zero", zero, 0);
    chk("mul_cout_ovf", {cout, ovf}, 0);
    collect(0, 0, lat, r, h, c, v, z);

    send(3'd2, 8'hF0, 8'h0F);
    for (int k = 0; k < 5; k++) begin
      chk("and_valid", out_valid, 1);
      chk("and_in_ready", in_ready, 0);
      chk("and_res", res, 8'h00);
      chk("and_zero", zero, 1);
      chk("and_cout", cout, 0);
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("and_ready_after", in_ready, 1);

    send(3'd6, 8'h81, 8'h09);
    collect(2, 1, lat, r, h, c, v, z);
    chk("shl_res", r, 8'h02);

    send(3'd7, 8'h0D, 8'h0B);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("arst_res", res, 0);
    chk("arst_res_hi", res_hi, 0);
    chk("arst_flags", {cout, ovf, zero}, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      chk("arst_no_result", out_valid, 0);
      @(posedge clk); #1;
    end
    send(3'd0, 8'h03, 8'h04);
    collect(0, 0, lat, r, h, c, v, z);
    chk("post_rst_add", r, 8'h07);

    for (int n = 0; n < 300; n++) begin
      ro = 3'($urandom);
      case ($urandom_range(0, 3))
        0: send(ro, 8'h80, W'($urandom));
        1: send(ro, W'($urandom), 8'hFF);
        default: send(ro, W'($urandom), W'($urandom));
      endcase
      collect(int'($urandom_range(0, 3)), 1, lat, r, h, c, v, z);
      chk("rand_lat", lat, (ro == 3'd7) ? W + 1 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
